abp_packet_rx: RTL and testbench
================================

# abp_packet_rx

Alternating-bit-protocol packet receiver: the receive-side counterpart of the ABP packet transmitter. It consumes fixed-length ABP frames from the MAC receive AXI-Stream, checks the frame length, and extracts the big-endian sequence value and the alternating bit. It presents them as one ABP hyperdata word on a valid/ready output to the ABP control logic, which then decides the acknowledgement and next packet.

## Interface
- `DATA_WIDTH`, default 8: RX AXI-Stream width in bits. Only 8 is supported.
- `VALUE_SIZE`, default 4: number of value bytes at the frame head.
- `PACKET_SIZE`, default 64: bytes per frame. Must be ≥ `VALUE_SIZE`+1.
- `aclk` input, 1 bit: clock. All logic is on the rising edge.
- `areset` input, 1 bit: reset, asynchronous, active-high.
- `s_eth_rx_tvalid` input, 1 bit: frame byte valid from the MAC.
- `s_eth_rx_tdata` input, `DATA_WIDTH` bits: frame byte.
- `s_eth_rx_tlast` input, 1 bit: last byte of the frame.
- `s_eth_rx_tready` output, 1 bit: byte accepted when high together with `tvalid`.
- `m_abp_valid` output, 1 bit: hyperdata valid.
- `m_abp_value` output, `VALUE_SIZE*8` bits: received sequence value.
- `m_abp_bit` output, 1 bit: received alternating bit.
- `m_abp_ready` input, 1 bit: consumer accepts hyperdata.
- `busy` output, 1 bit: high when state is not IDLE.
- `err_short` output, 1 bit: one-cycle pulse when a frame ends before byte `PACKET_SIZE`-1.
- `err_long` output, 1 bit: one-cycle pulse when a frame runs past byte `PACKET_SIZE`-1.
- `err_format` output, 1 bit: one-cycle pulse when the final byte has any of bits [7:1] set.

## Operation
- **States:** IDLE, RECV, DROP, HOLD. All outputs are registered or derived only from the state register.
- **Byte counter:** width `$clog2(PACKET_SIZE)`. It resets to 0 on entry to IDLE and increments on every accepted beat in RECV.
- **IDLE:** the first accepted beat is byte 0 and moves the block to RECV. A single-beat frame (tlast on byte 0) is short.
- **RECV, value capture:** byte k, for k < `VALUE_SIZE`, is written to `value[(VALUE_SIZE-1-k)*8 +: 8]` (big-endian). Bytes from `VALUE_SIZE` to `PACKET_SIZE`-2 are ignored; their contents are not checked.
- **RECV, final byte:** byte `PACKET_SIZE`-1 is captured as `bit` = tdata[0].
  - If bits [7:1] are nonzero, `err_format` pulses. The frame is still delivered.
- **Normal completion:** tlast on byte `PACKET_SIZE`-1 → HOLD.
- **Short frame:** tlast on any byte below `PACKET_SIZE`-1 → `err_short` pulses, the frame is discarded, state → IDLE.
- **Long frame:** byte `PACKET_SIZE`-1 arrives without tlast → `err_long` pulses, the frame is discarded, state → DROP.
  - `err_format` does not fire for a discarded frame.
- **DROP:** accepts and discards bytes until a beat with tlast, then → IDLE.
- **HOLD:**
  - `m_abp_valid` = 1, with `m_abp_value` and `m_abp_bit` stable.
  - `s_eth_rx_tready` = 0, which backpressures the MAC.
  - On `m_abp_valid && m_abp_ready` → IDLE.
- **Value arithmetic:** the value is passed through unmodified. Incrementing is the transmitter's job.
- **Mid-operation reset:** `areset` asserted in any state returns the block to IDLE immediately and drops any partial frame or pending hyperdata. No error pulses are generated.

## Timing
- **Reset values:**
  - `s_eth_rx_tready` = 0 while `areset` is high.
  - `m_abp_valid` = 0, `m_abp_value` = 0, `m_abp_bit` = 0.
  - `busy` = 0 and all `err_*` = 0.
- **After reset release:** `s_eth_rx_tready` = 1 from the first clock edge after `areset` deasserts.
- **tready:** `s_eth_rx_tready` = 1 in IDLE, RECV and DROP, and 0 in HOLD. Throughput is one byte per cycle with no bubbles inside a frame.
- **Output latency:** `m_abp_valid` rises on the cycle after the final beat is accepted.
- **Back-to-back frames:** after the output handshake, `tready` returns to 1 the following cycle. Minimum frame-to-frame gap is 1 cycle plus the consumer's ready delay.
- **Error pulses:** each `err_*` pulse is exactly 1 cycle, in the cycle after the offending beat.
- **Idle beats:** `tvalid` low in any state holds the state, counter and captured data.
- **Stability:** `m_abp_value` and `m_abp_bit` change only on entry to HOLD.

## Test plan
- **Nominal frame:** 64-byte frame with bytes 0–3 = 0x12,0x34,0x56,0x78, zeros after, byte 63 = 0x01, tlast on byte 63, `m_abp_ready`=1 → `m_abp_valid` for 1 cycle with value 0x12345678 and bit 1; `tready` is 0 only during that cycle.
- **Consumer backpressure:** same frame with `m_abp_ready` held 0 for 10 cycles, and a second frame waiting → `m_abp_valid` held with a stable value; `tready` = 0 for all 10 cycles; the second frame is received correctly after the handshake.
- **Short frame:** tlast on byte 20 → `err_short` pulses once, no `m_abp_valid`. The next nominal frame (value 0xDEADBEEF, bit 0) is then delivered correctly.
- **Long frame:** 70-byte frame with tlast on byte 69 → `err_long` pulses once, bytes 64–69 are consumed, no `m_abp_valid`. The following frame is delivered.
- **Bad final byte:** byte 63 = 0x03 → `err_format` pulse, frame delivered with `m_abp_bit` = 1.
- **Reset mid-frame:** assert `areset` after byte 30, then send a full frame with value 0x00000005 → no error pulses; the output is value 0x00000005 only.

Source files
------------

// File: rtl/abp_packet_rx_if.sv
// Receive-side ABP bundle: MAC RX byte stream in, ABP hyperdata word out.
// The slave modport is the receiver's view; the master modport is the MAC/consumer side.
interface abp_packet_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int VALUE_SIZE = 4
);
    logic                    s_eth_rx_tvalid;
    logic [DATA_WIDTH-1:0]   s_eth_rx_tdata;
    logic                    s_eth_rx_tlast;
    logic                    s_eth_rx_tready;
    logic                    m_abp_valid;
    logic [VALUE_SIZE*8-1:0] m_abp_value;
    logic                    m_abp_bit;
    logic                    m_abp_ready;

    modport slave (
        input  s_eth_rx_tvalid, s_eth_rx_tdata, s_eth_rx_tlast, m_abp_ready,
        output s_eth_rx_tready, m_abp_valid, m_abp_value, m_abp_bit
    );

    modport master (
        output s_eth_rx_tvalid, s_eth_rx_tdata, s_eth_rx_tlast, m_abp_ready,
        input  s_eth_rx_tready, m_abp_valid, m_abp_value, m_abp_bit
    );
endinterface

// File: rtl/abp_packet_rx.sv
// ABP packet receiver: checks fixed frame length, extracts the big-endian value
// and the alternating bit, and holds them as one hyperdata word until accepted.
module abp_packet_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int VALUE_SIZE  = 4,
    parameter int PACKET_SIZE = 64
) (
    input  logic             aclk,
    input  logic             areset,
    abp_packet_rx_if.slave   bus,
    output logic             busy,
    output logic             err_short,
    output logic             err_long,
    output logic             err_format
);
    localparam int             CW       = $clog2(PACKET_SIZE);
    localparam int             VW       = VALUE_SIZE * 8;
    localparam logic [CW-1:0]  LAST_IDX = CW'(PACKET_SIZE - 1);

    typedef enum logic [1:0] {IDLE, RECV, DROP, HOLD} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [VW-1:0]   r_shadow;
    logic [VW-1:0]   r_value;
    logic            r_bit;
    logic            r_valid;
    logic            r_tready;
    logic            r_err_short;
    logic            r_err_long;
    logic            r_err_format;

    logic            w_accept;
    logic            w_hs;
    logic [7:0]      w_byte;

    assign w_byte   = bus.s_eth_rx_tdata[7:0];
    assign w_accept = bus.s_eth_rx_tvalid & r_tready;
    assign w_hs     = r_valid & bus.m_abp_ready;

    // Value bytes land in a shadow register so the presented word only moves on entry to HOLD.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_value      <= '0;
            r_bit        <= 1'b0;
            r_valid      <= 1'b0;
            r_tready     <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_err_format <= 1'b0;
        end else begin
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_err_format <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tready <= 1'b1;
                    r_cnt    <= '0;
                    if (w_accept) begin
                        r_shadow[VW-1 -: 8] <= w_byte;
                        if (bus.s_eth_rx_tlast) begin
                            r_err_short <= 1'b1;
                        end else begin
                            r_state <= RECV;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                RECV: begin
                    if (w_accept) begin
                        if (r_cnt == LAST_IDX) begin
                            if (bus.s_eth_rx_tlast) begin
                                r_state      <= HOLD;
                                r_tready     <= 1'b0;
                                r_valid      <= 1'b1;
                                r_value      <= r_shadow;
                                r_bit        <= w_byte[0];
                                r_err_format <= |w_byte[7:1];
                            end else begin
                                r_err_long <= 1'b1;
                                r_state    <= DROP;
                            end
                        end else if (bus.s_eth_rx_tlast) begin
                            r_err_short <= 1'b1;
                            r_state     <= IDLE;
                            r_cnt       <= '0;
                        end else begin
                            for (int i = 1; i < VALUE_SIZE; i++) begin
                                if (r_cnt == CW'(i))
                                    r_shadow[(VALUE_SIZE-1-i)*8 +: 8] <= w_byte;
                            end
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                DROP: begin
                    if (w_accept && bus.s_eth_rx_tlast) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (w_hs) begin
                        r_state  <= IDLE;
                        r_valid  <= 1'b0;
                        r_tready <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.s_eth_rx_tready = r_tready;
    assign bus.m_abp_valid     = r_valid;
    assign bus.m_abp_value     = r_value;
    assign bus.m_abp_bit       = r_bit;
    assign busy                = (r_state != IDLE);
    assign err_short           = r_err_short;
    assign err_long            = r_err_long;
    assign err_format          = r_err_format;
endmodule

// File: tb/tb_abp_packet_rx.sv
// Directed bench for abp_packet_rx: expected hyperdata words are queued as frames
// are driven and popped when the receiver presents them.
module tb_abp_packet_rx;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic busy, err_short, err_long, err_format;

    abp_packet_rx_if #(.DATA_WIDTH(8), .VALUE_SIZE(4)) bus ();

    abp_packet_rx #(.DATA_WIDTH(8), .VALUE_SIZE(4), .PACKET_SIZE(64)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .bus        (bus.slave),
        .busy       (busy),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_format (err_format)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] v;
        logic        b;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0, n_err = 0;
    int n_out = 0, n_vcyc = 0, n_trlow = 0;
    int c_short = 0, c_long = 0, c_format = 0;
    logic        p_valid = 1'b0, p_hs = 1'b0;
    logic [31:0] p_val = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (!areset) begin
            if (err_short)  c_short++;
            if (err_long)   c_long++;
            if (err_format) c_format++;
            if (!bus.s_eth_rx_tready) n_trlow++;
            if (bus.m_abp_valid) begin
                n_vcyc++;
                chk("tready_in_hold", bus.s_eth_rx_tready, 0);
                if (p_valid && !p_hs) chk("value_stable", bus.m_abp_value, p_val);
            end
            if (bus.m_abp_valid && bus.m_abp_ready) begin
                n_out++;
                chk("sb_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_value", bus.m_abp_value, e.v);
                    chk("out_bit", bus.m_abp_bit, e.b);
                end
            end
            p_valid = bus.m_abp_valid;
            p_hs    = bus.m_abp_valid && bus.m_abp_ready;
            p_val   = bus.m_abp_value;
        end
    end

    task automatic send_frame(input int len, input logic [31:0] val, input logic [7:0] lastb,
                              input bit tlast_en);
        logic [7:0] b;
        bit ok;
        @(posedge aclk); #1;
        for (int i = 0; i < len; i++) begin
            if (i < 4)       b = val[31-8*i -: 8];
            else if (i == 63) b = lastb;
            else             b = 8'h00;
            bus.s_eth_rx_tvalid = 1'b1;
            bus.s_eth_rx_tdata  = b;
            bus.s_eth_rx_tlast  = tlast_en && (i == len - 1);
            ok = 1'b0;
            for (int w = 0; w < 100 && !ok; w++) begin
                @(negedge aclk);
                if (bus.s_eth_rx_tready) ok = 1'b1;
                @(posedge aclk); #1;
            end
            if (!ok) begin
                chk("beat_timeout", 0, 1);
                break;
            end
        end
        bus.s_eth_rx_tvalid = 1'b0;
        bus.s_eth_rx_tlast  = 1'b0;
    endtask

    task automatic wait_out(input int target);
        for (int i = 0; i < 200 && n_out < target; i++) @(negedge aclk);
        chk("out_count", n_out, target);
    endtask

    task automatic push(input logic [31:0] v, input logic b);
        exp_t e;
        e.v = v; e.b = b;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, t0;
        bus.s_eth_rx_tvalid = 1'b0;
        bus.s_eth_rx_tdata  = '0;
        bus.s_eth_rx_tlast  = 1'b0;
        bus.m_abp_ready     = 1'b1;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_tready", bus.s_eth_rx_tready, 0);
        chk("rst_valid", bus.m_abp_valid, 0);
        chk("rst_value", bus.m_abp_value, 0);
        chk("rst_bit", bus.m_abp_bit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_short, err_long, err_format}, 0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("tready_before_edge", bus.s_eth_rx_tready, 0);
        @(negedge aclk);
        chk("tready_after_release", bus.s_eth_rx_tready, 1);

        // Nominal frame
        v0 = n_vcyc; t0 = n_trlow;
        push(32'h12345678, 1'b1);
        send_frame(64, 32'h12345678, 8'h01, 1'b1);
        wait_out(1);
        repeat (3) @(negedge aclk);
        chk("nom_valid_cycles", n_vcyc - v0, 1);
        chk("nom_tready_low", n_trlow - t0, 1);
        chk("nom_busy_idle", busy, 0);

        // Consumer backpressure with a second frame waiting
        bus.m_abp_ready = 1'b0;
        push(32'hA1B2C3D4, 1'b0);
        send_frame(64, 32'hA1B2C3D4, 8'h00, 1'b1);
        push(32'h0BADF00D, 1'b1);
        fork
            send_frame(64, 32'h0BADF00D, 8'h01, 1'b1);
            begin
                for (int i = 0; i < 50 && !bus.m_abp_valid; i++) @(negedge aclk);
                repeat (10) begin
                    @(negedge aclk);
                    chk("bp_valid_held", bus.m_abp_valid, 1);
                    chk("bp_tready_low", bus.s_eth_rx_tready, 0);
                    chk("bp_busy", busy, 1);
                end
                @(posedge aclk); #1 bus.m_abp_ready = 1'b1;
            end
        join
        wait_out(3);

        // Short frame then a good one
        send_frame(21, 32'h11111111, 8'h01, 1'b1);
        repeat (3) @(negedge aclk);
        chk("short_pulses", c_short, 1);
        chk("short_no_out", n_out, 3);
        push(32'hDEADBEEF, 1'b0);
        send_frame(64, 32'hDEADBEEF, 8'h00, 1'b1);
        wait_out(4);

        // Long frame then a good one
        send_frame(70, 32'h22222222, 8'h01, 1'b1);
        repeat (3) @(negedge aclk);
        chk("long_pulses", c_long, 1);
        chk("long_no_out", n_out, 4);
        chk("long_fmt_quiet", c_format, 0);
        chk("long_idle", busy, 0);
        push(32'hCAFEF00D, 1'b1);
        send_frame(64, 32'hCAFEF00D, 8'h01, 1'b1);
        wait_out(5);

        // Bad final byte: still delivered
        push(32'hA5A5A5A5, 1'b1);
        send_frame(64, 32'hA5A5A5A5, 8'h03, 1'b1);
        wait_out(6);
        chk("format_pulses", c_format, 1);

        // Reset mid-frame
        send_frame(31, 32'h33333333, 8'h00, 1'b0);
        chk("mid_busy", busy, 1);
        @(posedge aclk); #1 areset = 1'b1;
        @(negedge aclk);
        chk("mid_rst_tready", bus.s_eth_rx_tready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_value", bus.m_abp_value, 0);
        @(posedge aclk); #1 areset = 1'b0;
        push(32'h00000005, 1'b0);
        send_frame(64, 32'h00000005, 8'h00, 1'b1);
        wait_out(7);
        repeat (5) @(negedge aclk);
        chk("final_errs", {c_short[7:0], c_long[7:0], c_format[7:0]}, 24'h010101);
        chk("final_outs", n_out, 7);
        chk("sb_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
